// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: memop one-hot layout, bus widths, size codes.
package dmem_ctrl_pkg;

  localparam int unsigned MMOP_W   = 8;
  localparam int unsigned MMOP_LB  = 0;
  localparam int unsigned MMOP_LBU = 1;
  localparam int unsigned MMOP_LH  = 2;
  localparam int unsigned MMOP_LHU = 3;
  localparam int unsigned MMOP_LW  = 4;
  localparam int unsigned MMOP_SB  = 5;
  localparam int unsigned MMOP_SH  = 6;
  localparam int unsigned MMOP_SW  = 7;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  function automatic logic op_is_store(input logic [MMOP_W-1:0] op);
    return op[MMOP_SB] | op[MMOP_SH] | op[MMOP_SW];
  endfunction

  function automatic logic op_misaligned(input logic [MMOP_W-1:0] op, input logic [1:0] low);
    return ((op[MMOP_LH] | op[MMOP_LHU] | op[MMOP_SH]) & low[0]) |
           ((op[MMOP_LW] | op[MMOP_SW]) & (|low));
  endfunction

endpackage

// File: rtl/dmem_store_fmt.sv
// Combinational request formatter: access size, byte strobes and lane-replicated store data.
module dmem_store_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [MMOP_W-1:0] op,
  input  logic [1:0]        addr_low,
  input  logic [DATA_W-1:0] wdata,
  output logic              is_store,
  output logic [SIZE_W-1:0] size,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] lane_data
);

  logic is_byte;
  logic is_half;
  logic is_word;

  always_comb begin
    is_byte   = op[MMOP_LB] | op[MMOP_LBU] | op[MMOP_SB];
    is_half   = op[MMOP_LH] | op[MMOP_LHU] | op[MMOP_SH];
    is_word   = op[MMOP_LW] | op[MMOP_SW];
    is_store  = op_is_store(op);
    size      = SIZE_BYTE;
    wstrb     = '0;
    lane_data = wdata;
    if (is_byte) begin
      size      = SIZE_BYTE;
      wstrb     = STRB_W'(4'b0001 << addr_low);
      lane_data = {4{wdata[7:0]}};
    end
    if (is_half) begin
      size      = SIZE_HALF;
      wstrb     = addr_low[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{wdata[15:0]}};
    end
    if (is_word) begin
      size      = SIZE_WORD;
      wstrb     = 4'b1111;
      lane_data = wdata;
    end
    // loads never enable write lanes
    if (!is_store) wstrb = '0;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding SRAM-like transaction per memory instruction.
// Optional alignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_valid_i,
  input  logic [MMOP_W-1:0] dm_memop_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic              dm_stall_i,
  input  logic              dm_flush_i,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [SIZE_W-1:0] data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [STRB_W-1:0] data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic [DATA_W-1:0] dm_memdata_o,
  output logic [1:0]        dm_memaddr_low_o,
  output logic              dm_stall_o,
  output logic              dm_adel_o,
  output logic              dm_ades_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [MMOP_W-1:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;
  logic [1:0]        low_q;
  logic              access;
  logic              misalign;
  logic              capture;
  logic              load_hold;
  logic              stall_c;
  logic              fmt_store;
  logic [STRB_W-1:0] fmt_wstrb;

  assign access = dm_valid_i & (|dm_memop_i);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign  = (state == S_IDLE) & access & ~dm_flush_i & op_misaligned(dm_memop_i, dm_addr_i[1:0]);
  assign dm_adel_o = rst_n & misalign & ~op_is_store(dm_memop_i);
  assign dm_ades_o = rst_n & misalign &  op_is_store(dm_memop_i);
`else
  assign misalign  = 1'b0;
  assign dm_adel_o = 1'b0;
  assign dm_ades_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state, capture/hold strobes and the stall request
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_hold = 1'b0;
    stall_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !dm_flush_i && !misalign) begin
          capture   = 1'b1;
          stall_c   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (dm_flush_i)             state_nxt = data_sram_addr_ok ? S_DRAIN : S_IDLE;
        else if (data_sram_addr_ok) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          load_hold = ~dm_flush_i;
          state_nxt = (dm_flush_i || !dm_stall_i) ? S_IDLE : S_DONE;
        end else begin
          stall_c = 1'b1;
          if (dm_flush_i) state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (dm_flush_i || !dm_stall_i) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        stall_c = dm_valid_i;
        if (data_sram_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // request fields, stable from capture until the next access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      op_q    <= dm_memop_i;
      addr_q  <= dm_addr_i;
      wdata_q <= dm_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      low_q  <= '0;
    end else if (load_hold) begin
      hold_q <= data_sram_rdata;
      low_q  <= addr_q[1:0];
    end
  end

  dmem_store_fmt u_fmt (
    .op        (op_q),
    .addr_low  (addr_q[1:0]),
    .wdata     (wdata_q),
    .is_store  (fmt_store),
    .size      (data_sram_size),
    .wstrb     (fmt_wstrb),
    .lane_data (data_sram_wdata)
  );

  assign data_sram_req    = (state == S_REQ);
  assign data_sram_wr     = data_sram_req & fmt_store;
  assign data_sram_wstrb  = data_sram_req ? fmt_wstrb : '0;
  assign data_sram_addr   = addr_q;
  assign dm_memdata_o     = load_hold ? data_sram_rdata : hold_q;
  assign dm_memaddr_low_o = load_hold ? addr_q[1:0] : low_q;
  assign dm_stall_o       = stall_c & rst_n;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus randomized transactions vs. a transaction model.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        dm_valid_i;
  logic [7:0]  dm_memop_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_stall_i;
  logic        dm_flush_i;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [31:0] dm_memdata_o;
  logic [1:0]  dm_memaddr_low_o;
  logic        dm_stall_o;
  logic        dm_adel_o;
  logic        dm_ades_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_req_cyc = 0;
  logic [31:0] exp_hold;
  logic [1:0]  exp_low;

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .dm_valid_i(dm_valid_i), .dm_memop_i(dm_memop_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_stall_i(dm_stall_i), .dm_flush_i(dm_flush_i),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .dm_memdata_o(dm_memdata_o), .dm_memaddr_low_o(dm_memaddr_low_o),
    .dm_stall_o(dm_stall_o), .dm_adel_o(dm_adel_o), .dm_ades_o(dm_ades_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (data_sram_req) n_req_cyc <= n_req_cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // op index: 0 lb 1 lbu 2 lh 3 lhu 4 lw 5 sb 6 sh 7 sw
  function automatic logic [1:0] m_size(input int op);
    case (op)
      0, 1, 5: return 2'd0;
      2, 3, 6: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input int op, input logic [31:0] a);
    int n, lanes, sh;
    if (op < 5) return 4'd0;
    n     = 1 << m_size(op);
    lanes = (1 << n) - 1;
    sh    = int'(a[1:0]) & (4 - n);
    return 4'(lanes << sh);
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] wd);
    case (m_size(op))
      2'd0:    return 32'(wd[7:0]) * 32'h01010101;
      2'd1:    return 32'(wd[15:0]) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_align(input int op, input logic [31:0] a);
    if (m_size(op) == 2'd1) return {a[31:1], 1'b0};
    if (m_size(op) == 2'd2) return {a[31:2], 2'b00};
    return a;
  endfunction

  // fl: 0 none, 1 flush in IDLE, 2 in REQ w/o addr_ok, 3 in REQ with addr_ok,
  //     4 in first WAIT cycle w/o data_ok (dd>=2), 5 in WAIT with data_ok
  task automatic do_access(input int op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int ao, input int dd,
                           input int st, input int fl);
    int rc0, exp_rc;
    bit drain;
    rc0 = n_req_cyc; exp_rc = 0; drain = 0;
    dm_valid_i = 1'b1; dm_memop_i = 8'(1 << op); dm_addr_i = a; dm_wdata_i = wd;
    dm_flush_i = (fl == 1);
    @(negedge clk);
    chk("idle_stall", 32'(dm_stall_o), (fl == 1) ? 0 : 1);
    chk("idle_req", 32'(data_sram_req), 0);
    chk("idle_adel_ades", {30'd0, dm_adel_o, dm_ades_o}, 0);
    chk("idle_data", dm_memdata_o, exp_hold);
    @(posedge clk); #1;
    dm_flush_i = 1'b0;
    if (fl == 2) begin
      dm_flush_i = 1'b1;
      @(negedge clk);
      chk("fl_req_req", 32'(data_sram_req), 1);
      @(posedge clk); #1;
      exp_rc = 1;
    end else if (fl != 1) begin
      for (int i = 0; i <= ao; i++) begin
        data_sram_addr_ok = (i == ao);
        dm_flush_i = (fl == 3) && (i == ao);
        @(negedge clk);
        chk("req", 32'(data_sram_req), 1);
        chk("req_stall", 32'(dm_stall_o), 1);
        if (i == ao) begin
          chk("req_wr", 32'(data_sram_wr), (op >= 5) ? 1 : 0);
          chk("req_size", 32'(data_sram_size), 32'(m_size(op)));
          chk("req_addr", data_sram_addr, a);
          chk("req_wstrb", 32'(data_sram_wstrb), 32'(m_wstrb(op, a)));
          if (op >= 5) chk("req_wdata", data_sram_wdata, m_wdata(op, wd));
        end
        @(posedge clk); #1;
      end
      exp_rc = ao + 1;
      data_sram_addr_ok = 1'b0; dm_flush_i = 1'b0;
      drain = (fl == 3);
      for (int j = 1; j <= dd; j++) begin
        data_sram_data_ok = (j == dd);
        data_sram_rdata   = (j == dd) ? rd : $urandom;
        dm_flush_i = ((fl == 4) && (j == 1)) || ((fl == 5) && (j == dd));
        dm_stall_i = (fl == 0) && (st > 0) && (j == dd);
        @(negedge clk);
        chk("wait_req", 32'(data_sram_req), 0);
        if (drain) begin
          chk("drain_stall", 32'(dm_stall_o), 1);
          chk("drain_data", dm_memdata_o, exp_hold);
        end else if (j < dd) begin
          chk("wait_stall", 32'(dm_stall_o), 1);
          chk("wait_data", dm_memdata_o, exp_hold);
        end else begin
          chk("dok_stall", 32'(dm_stall_o), 0);
          if (fl != 5) begin
            chk("dok_data", dm_memdata_o, rd);
            chk("dok_low", 32'(dm_memaddr_low_o), 32'(a[1:0]));
          end
        end
        @(posedge clk); #1;
        if ((fl == 4) && (j == 1)) drain = 1;
      end
      if (fl == 0) begin
        exp_hold = rd;
        exp_low  = a[1:0];
      end
      dm_valid_i = 1'b0; data_sram_data_ok = 1'b0; dm_flush_i = 1'b0;
      if ((fl == 0) && (st > 0)) begin
        for (int k = 1; k <= st; k++) begin
          dm_stall_i = (k < st);
          @(negedge clk);
          chk("done_req", 32'(data_sram_req), 0);
          chk("done_data", dm_memdata_o, rd);
          chk("done_low", 32'(dm_memaddr_low_o), 32'(a[1:0]));
          @(posedge clk); #1;
        end
      end
    end
    dm_valid_i = 1'b0; data_sram_data_ok = 1'b0; dm_flush_i = 1'b0; dm_stall_i = 1'b0;
    @(negedge clk);
    chk("end_req", 32'(data_sram_req), 0);
    chk("end_data", dm_memdata_o, exp_hold);
    chk("end_low", 32'(dm_memaddr_low_o), 32'(exp_low));
    chk("req_cnt", n_req_cyc - rc0, exp_rc);
    @(posedge clk); #1;
  endtask

  int          r_op, r_ao, r_dd, r_st, r_fl, r_sel;
  logic [31:0] r_a;

  initial begin
    rst_n = 1'b0; dm_valid_i = 1'b0; dm_memop_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    dm_stall_i = 1'b0; dm_flush_i = 1'b0; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    exp_hold = '0; exp_low = '0;
    #3;
    chk("rst_req", 32'(data_sram_req), 0);
    chk("rst_stall", 32'(dm_stall_o), 0);
    chk("rst_data", dm_memdata_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    do_access(4, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 0);
    do_access(5, 32'h0000_2003, 32'h0000_00A5, 32'h0, 1, 1, 0, 0);
    do_access(1, 32'h0000_2001, 32'h0, 32'h0000_00C3, 0, 1, 4, 0);
    do_access(4, 32'h0000_1008, 32'h0, 32'h1234_5678, 0, 3, 0, 4);
    do_access(6, 32'h0000_3002, 32'h0000_BEEF, 32'h0, 2, 2, 0, 0);
    do_access(7, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 0, 1, 1, 0);
    do_access(2, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 1, 1, 0, 1);
    do_access(3, 32'h0000_4002, 32'h0, 32'h6666_7777, 2, 1, 0, 2);
    do_access(0, 32'h0000_4003, 32'h0, 32'h8888_9999, 1, 2, 0, 3);
    do_access(4, 32'h0000_400C, 32'h0, 32'hAAAA_BBBB, 0, 2, 0, 5);

`ifdef DMEM_ALIGN_CHECK_EN
    dm_valid_i = 1'b1; dm_memop_i = 8'h10; dm_addr_i = 32'h0000_1002;
    @(negedge clk);
    chk("mis_lw_adel", 32'(dm_adel_o), 1);
    chk("mis_lw_ades", 32'(dm_ades_o), 0);
    chk("mis_lw_req", 32'(data_sram_req), 0);
    chk("mis_lw_stall", 32'(dm_stall_o), 0);
    @(posedge clk); #1;
    dm_memop_i = 8'h40; dm_addr_i = 32'h0000_1001;
    @(negedge clk);
    chk("mis_sh_ades", 32'(dm_ades_o), 1);
    chk("mis_sh_adel", 32'(dm_adel_o), 0);
    chk("mis_sh_req", 32'(data_sram_req), 0);
    @(posedge clk); #1;
    dm_valid_i = 1'b0;
    @(negedge clk);
    chk("mis_after_req", 32'(data_sram_req), 0);
    @(posedge clk); #1;
`else
    do_access(4, 32'h0000_1002, 32'h0, 32'h0BAD_0002, 0, 1, 0, 0);
    do_access(6, 32'h0000_1001, 32'h0000_BEEF, 32'h0, 0, 1, 0, 0);
`endif

    // asynchronous reset while a load waits for data
    dm_valid_i = 1'b1; dm_memop_i = 8'h10; dm_addr_i = 32'h0000_3000;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(data_sram_req), 0);
    chk("arst_wr", 32'(data_sram_wr), 0);
    chk("arst_wstrb", 32'(data_sram_wstrb), 0);
    chk("arst_stall", 32'(dm_stall_o), 0);
    chk("arst_data", dm_memdata_o, 0);
    chk("arst_low", 32'(dm_memaddr_low_o), 0);
    chk("arst_adel_ades", {30'd0, dm_adel_o, dm_ades_o}, 0);
    exp_hold = '0; exp_low = '0;
    dm_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_req", 32'(data_sram_req), 0);
    end
    @(posedge clk); #1;
    do_access(4, 32'h0000_3000, 32'h0, 32'h0F0F_1E1E, 1, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r_op  = $urandom_range(7);
      r_a   = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
      r_a   = m_align(r_op, r_a);
`endif
      r_ao  = $urandom_range(3);
      r_dd  = $urandom_range(1, 3);
      r_sel = $urandom_range(9);
      r_fl  = (r_sel < 5) ? 0 : r_sel - 4;
      if ((r_fl == 4) && (r_dd < 2)) r_dd = 2;
      r_st  = (r_fl == 0) ? $urandom_range(2) : 0;
      do_access(r_op, r_a, $urandom, $urandom, r_ao, r_dd, r_st, r_fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
